dmem_sized: RTL and testbench
=============================

Name: dmem_sized

Overview:
- Parametrised byte-addressed data memory; successor to the single-byte data memory in the MIPS datapath.
- Supports byte, half and word loads and stores, little-endian, with sign or zero extension on reads.
- Keeps the serial byte-preload port used by the testbench and boot loader.
- Sits between the ALU address path and the writeback mux; reads have a registered 1-cycle latency and a valid strobe.

Parameters:
- DEPTH, 1024, memory size in bytes; power of two, at least 8.
- LOAD_BASE, 0, byte address where the preload counter starts after reset.
- AW, $clog2(DEPTH), localparam; internal byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- address  in  32  byte address; only bits [AW-1:0] are used (modulo DEPTH).
- write_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- ready  in  1  access enable; when 0, no access occurs.
- load  in  1  preload strobe; highest priority.
- store  in  8  preload byte.
- read_data  out  32  registered load result.
- read_valid  out  1  one-cycle pulse: read_data was updated this cycle.
- misalign  out  1  registered pulse: the access in the previous cycle was rejected.
- load_count  out  AW  current preload write pointer.
- load_full  out  1  sticky: the preload pointer has wrapped at least once.

Behaviour:
- Reset (rst=1 at clk edge):
  - read_data=0, read_valid=0, misalign=0, load_count=LOAD_BASE, load_full=0.
  - Memory array contents are not reset.
  - rst overrides load and any access in the same cycle.
- Priority each cycle: rst > load > ~ready > MemWrite > MemRead.
- Preload (load=1):
  - mem[load_count] <= store; load_count increments.
  - Wrap from DEPTH-1 to 0 sets load_full.
  - MemWrite and MemRead are ignored; read_valid=0.
- Stall (ready=0, load=0): no memory change; read_data holds; read_valid=0; misalign=0.
- Alignment:
  - Half access requires addr[0]=0.
  - Word access requires addr[1:0]=0.
  - mem_size=11 is always treated as misaligned.
- Store (MemWrite=1, aligned): byte lanes are written in the same edge, little-endian.
  - mem[a] <= write_data[7:0].
  - For half and word: mem[a+1] <= write_data[15:8].
  - For word only: mem[a+2] <= write_data[23:16], mem[a+3] <= write_data[31:24].
  - If MemRead is also high: the write wins, no read occurs, read_valid=0.
- Load (MemRead=1, MemWrite=0, aligned):
  - Next edge: read_data is assembled little-endian and extended per mem_unsigned.
  - read_valid=1 for that cycle.
  - Latency is exactly 1 clock.
- Read of an address written in the same cycle: not allowed (write has priority). Read in the next cycle returns the new data.
- Address wrap: an aligned access never crosses DEPTH because DEPTH is a power of two.
- Misaligned access: behaviour is set by DMEM_MISALIGN_TRAP_EN (below).

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access (or mem_size=11) writes nothing.
  - read_data holds and read_valid=0.
  - misalign pulses 1 on the next edge.
- Not defined:
  - Low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds.
  - mem_size=11 is treated as word.
  - misalign is tied to 0.

Decomposition:
- Shared package dmem_pkg holds:
  - mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD).
  - An enum for the access decision (ACC_NONE, ACC_LOAD, ACC_WRITE, ACC_READ, ACC_BAD).
- One natural sub-module, dmem_load_ext: combinational alignment, extension and lane assembly from 4 byte lanes plus mem_size and mem_unsigned to 32 bits. It is unit-testable alone.

Test Plan:
- rst, then load 8 bytes 0x11..0x88 -> load_count=LOAD_BASE+8, mem[0..7] holds 0x11..0x88, load_full=0.
- Word read at addr 4 after that preload -> one cycle later read_data=0x88776655, read_valid pulses for 1 cycle.
- sb 0x000000F0 to addr 9, then lb and lbu at addr 9 -> 0xFFFFFFF0, then 0x000000F0.
- sh 0xBEEF to addr 2, then lh at 2 -> 0xFFFFBEEF; also lw at 0 -> 0xBEEF2211.
- lw at addr 6:
  - With DMEM_MISALIGN_TRAP_EN: misalign=1, read_valid=0, read_data unchanged.
  - Without: returns the word at addr 4, misalign=0.
- MemWrite and MemRead asserted together with ready=0 -> nothing changes. Then preload DEPTH+1 bytes -> load_full=1, load_count=LOAD_BASE+1 mod DEPTH. Assert rst during a load -> load_count=LOAD_BASE and that byte is not written.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory: access-size encodings,
// the per-cycle access decision and the alignment rules.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [2:0] {
    ACC_NONE  = 3'd0,
    ACC_LOAD  = 3'd1,
    ACC_WRITE = 3'd2,
    ACC_READ  = 3'd3,
    ACC_BAD   = 3'd4
  } acc_e;

  // The reserved size can never be a legal access.
  function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b1;
    endcase
  endfunction

  function automatic mem_size_e eff_size(input mem_size_e sz);
    return (sz == SZ_RSVD) ? SZ_WORD : sz;
  endfunction

  function automatic logic [1:0] align_lo(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load result assembly: takes four little-endian byte lanes starting at the
// access address and produces the sign- or zero-extended 32-bit load value.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] lanes,
  input  mem_size_e   size,
  input  logic        mem_unsigned,
  output logic [31:0] data
);

  logic byte_sign;
  logic half_sign;

  assign byte_sign = ~mem_unsigned & lanes[7];
  assign half_sign = ~mem_unsigned & lanes[15];

  // Reserved size is assembled as a full word.
  always_comb begin
    data = lanes;
    case (size)
      SZ_BYTE: data = {{24{byte_sign}}, lanes[7:0]};
      SZ_HALF: data = {{16{half_sign}}, lanes[15:0]};
      default: data = lanes;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed data memory with byte/half/word little-endian access, registered
// 1-cycle loads and a serial byte preload port. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter  int DEPTH     = 1024,
  parameter  int LOAD_BASE = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   address,
  input  logic [31:0]   write_data,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [1:0]    mem_size,
  input  logic          mem_unsigned,
  input  logic          ready,
  input  logic          load,
  input  logic [7:0]    store,
  output logic [31:0]   read_data,
  output logic          read_valid,
  output logic          misalign,
  output logic [AW-1:0] load_count,
  output logic          load_full
);

  logic [7:0]    mem [DEPTH];
  mem_size_e     size_req;
  mem_size_e     size_eff;
  logic [AW-1:0] addr_raw;
  logic [AW-1:0] a0, a1, a2, a3;
  logic          bad;
  acc_e          acc;
  logic [31:0]   lanes;
  logic [31:0]   load_word;
  logic          unused_addr_hi;

  assign size_req       = mem_size_e'(mem_size);
  assign size_eff       = eff_size(size_req);
  assign addr_raw       = address[AW-1:0];
  assign unused_addr_hi = ^address[31:AW];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign bad = is_misaligned(size_req, addr_raw[1:0]);
  assign a0  = addr_raw;
`else
  // Without trapping, the low bits are silently forced to the access alignment.
  assign bad = 1'b0;
  assign a0  = {addr_raw[AW-1:2], align_lo(size_req, addr_raw[1:0])};
`endif

  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  // Priority: load > stall > write > read; rst is applied in the registers.
  always_comb begin
    acc = ACC_NONE;
    if (load) begin
      acc = ACC_LOAD;
    end else if (!ready) begin
      acc = ACC_NONE;
    end else if (MemWrite || MemRead) begin
      if (bad) begin
        acc = ACC_BAD;
      end else if (MemWrite) begin
        acc = ACC_WRITE;
      end else begin
        acc = ACC_READ;
      end
    end
  end

  // The array itself is never reset; rst only blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc == ACC_LOAD) begin
        mem[load_count] <= store;
      end else if (acc == ACC_WRITE) begin
        mem[a0] <= write_data[7:0];
        if (size_eff != SZ_BYTE) begin
          mem[a1] <= write_data[15:8];
        end
        if (size_eff == SZ_WORD) begin
          mem[a2] <= write_data[23:16];
          mem[a3] <= write_data[31:24];
        end
      end
    end
  end

  assign lanes = {mem[a3], mem[a2], mem[a1], mem[a0]};

  dmem_load_ext u_load_ext (
    .lanes        (lanes),
    .size         (size_eff),
    .mem_unsigned (mem_unsigned),
    .data         (load_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= (acc == ACC_READ);
      if (acc == ACC_READ) begin
        read_data <= load_word;
      end
    end
  end

  // load_full is sticky once the pointer has wrapped past the top of memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_count <= AW'(LOAD_BASE);
      load_full  <= 1'b0;
    end else if (acc == ACC_LOAD) begin
      load_count <= load_count + AW'(1);
      if (load_count == AW'(DEPTH - 1)) begin
        load_full <= 1'b1;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (acc == ACC_BAD);
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sized.sv
// Directed self-checking bench for dmem_sized: preload, sized loads/stores,
// priority rules, misaligned handling in both build modes and preload wrap.
module tb_dmem_sized;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic          MemWrite;
  logic          MemRead;
  logic [1:0]    mem_size;
  logic          mem_unsigned;
  logic          ready;
  logic          load;
  logic [7:0]    store;
  logic [31:0]   read_data;
  logic          read_valid;
  logic          misalign;
  logic [AW-1:0] load_count;
  logic          load_full;

  int vectors;
  int miscompares;
  logic [31:0] held;

  dmem_sized #(.DEPTH(DEPTH), .LOAD_BASE(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .write_data   (write_data),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .ready        (ready),
    .load         (load),
    .store        (store),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .misalign     (misalign),
    .load_count   (load_count),
    .load_full    (load_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rs, input logic ld, input logic [7:0] st,
                               input logic rdy, input logic mw, input logic mr,
                               input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] wd);
    rst          = rs;
    load         = ld;
    store        = st;
    ready        = rdy;
    MemWrite     = mw;
    MemRead      = mr;
    mem_size     = sz;
    mem_unsigned = un;
    address      = a;
    write_data   = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rdMem(input logic [1:0] sz, input logic un, input logic [31:0] a);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, sz, un, a, 32'h0);
  endtask

  task automatic wrMem(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, sz, 1'b0, a, wd);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    $display("[TB] starting dmem_sized bench, trap mode %0d", TRAP);

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    checkOutput("reset read_data", read_data, 32'h0);
    checkOutput("reset read_valid", 32'(read_valid), 32'h0);
    checkOutput("reset misalign", 32'(misalign), 32'h0);
    checkOutput("reset load_count", 32'(load_count), 32'h0);
    checkOutput("reset load_full", 32'(load_full), 32'h0);

    // Preload 0x11..0x88 with a read request that load must override.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0,
                    32'h0, 32'h0);
    end
    checkOutput("preload count", 32'(load_count), 32'd8);
    checkOutput("preload full", 32'(load_full), 32'h0);
    checkOutput("preload no read", 32'(read_valid), 32'h0);

    rdMem(SZ_WORD, 1'b0, 32'h4);
    checkOutput("lw 4 data", read_data, 32'h88776655);
    checkOutput("lw 4 valid", 32'(read_valid), 32'h1);
    idle();
    checkOutput("valid pulse ends", 32'(read_valid), 32'h0);
    checkOutput("data holds idle", read_data, 32'h88776655);
    rdMem(SZ_WORD, 1'b0, 32'h0);
    checkOutput("lw 0 data", read_data, 32'h44332211);

    wrMem(SZ_BYTE, 32'h9, 32'h000000F0);
    checkOutput("sb no valid", 32'(read_valid), 32'h0);
    rdMem(SZ_BYTE, 1'b0, 32'h9);
    checkOutput("lb 9", read_data, 32'hFFFFFFF0);
    rdMem(SZ_BYTE, 1'b1, 32'h9);
    checkOutput("lbu 9", read_data, 32'h000000F0);

    wrMem(SZ_HALF, 32'h2, 32'h1234BEEF);
    rdMem(SZ_HALF, 1'b0, 32'h2);
    checkOutput("lh 2", read_data, 32'hFFFFBEEF);
    rdMem(SZ_WORD, 1'b0, 32'h0);
    checkOutput("lw 0 after sh", read_data, 32'hBEEF2211);
    rdMem(SZ_HALF, 1'b1, 32'h2);
    checkOutput("lhu 2", read_data, 32'h0000BEEF);

    rdMem(SZ_WORD, 1'b0, 32'h6);
    held = TRAP ? 32'h0000BEEF : 32'h88776655;
    checkOutput("lw 6 data", read_data, held);
    checkOutput("lw 6 valid", 32'(read_valid), TRAP ? 32'h0 : 32'h1);
    checkOutput("lw 6 misalign", 32'(misalign), TRAP ? 32'h1 : 32'h0);
    idle();
    checkOutput("misalign pulse ends", 32'(misalign), 32'h0);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h4, 32'hDEADBEEF);
    checkOutput("stall no valid", 32'(read_valid), 32'h0);
    checkOutput("stall data holds", read_data, held);
    rdMem(SZ_WORD, 1'b0, 32'h4);
    checkOutput("stall no write", read_data, 32'h88776655);

    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'hC, 32'hCAFEF00D);
    checkOutput("write wins valid", 32'(read_valid), 32'h0);
    checkOutput("write wins data", read_data, 32'h88776655);
    rdMem(SZ_WORD, 1'b0, 32'hC);
    checkOutput("lw 12", read_data, 32'hCAFEF00D);
    rdMem(SZ_BYTE, 1'b0, 32'hF);
    checkOutput("lb 15", read_data, 32'hFFFFFFCA);
    rdMem(SZ_HALF, 1'b0, 32'hE);
    checkOutput("lh 14", read_data, 32'hFFFFCAFE);
    rdMem(SZ_HALF, 1'b1, 32'hC);
    checkOutput("lhu 12", read_data, 32'h0000F00D);

    rdMem(SZ_RSVD, 1'b0, 32'hD);
    checkOutput("rsvd data", read_data, TRAP ? 32'h0000F00D : 32'hCAFEF00D);
    checkOutput("rsvd misalign", 32'(misalign), TRAP ? 32'h1 : 32'h0);

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    checkOutput("rst2 read_data", read_data, 32'h0);
    checkOutput("rst2 load_count", 32'(load_count), 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i), 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    end
    checkOutput("wrap count", 32'(load_count), 32'h0);
    checkOutput("wrap full", 32'(load_full), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap+1 count", 32'(load_count), 32'h1);
    checkOutput("full sticky", 32'(load_full), 32'h1);

    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    checkOutput("rst over load count", 32'(load_count), 32'h0);
    checkOutput("rst clears full", 32'(load_full), 32'h0);
    rdMem(SZ_WORD, 1'b0, 32'h0);
    checkOutput("rst blocks write", read_data, 32'h030201A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
